// File: rtl/serial_subtractor.sv
// serial_subtractor: wide a - b computed one CHUNK_WIDTH slice per cycle,
// borrow rippled between slices through a register. Operands arrive and the
// {borrow, difference} result leaves over valid/ready handshakes.
module serial_subtractor #(
    parameter int ADDER_WIDTH = 116,
    parameter int CHUNK_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ADDER_WIDTH-1:0] a,
    input  logic [ADDER_WIDTH-1:0] b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ADDER_WIDTH:0]   diff
);
    // Derived sizes: operands are zero-padded up to a whole number of chunks so
    // the last (possibly partial) slice reads zeros above ADDER_WIDTH.
    localparam int NCHUNK = (ADDER_WIDTH + CHUNK_WIDTH - 1) / CHUNK_WIDTH;
    localparam int PW     = NCHUNK * CHUNK_WIDTH;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state_q, state_d;
    logic [PW-1:0]          a_q, b_q;
    logic                   borrow_q;
    logic [IDXW-1:0]        idx_q;
    logic [ADDER_WIDTH:0]   diff_q;
    logic [CHUNK_WIDTH:0]   slice;
    logic                   last;

    // Current slice: operands are shifted down each RUN cycle, so the active
    // chunk always sits in the low CHUNK_WIDTH bits.
    always_comb begin
        slice = {1'b0, a_q[CHUNK_WIDTH-1:0]}
              - {1'b0, b_q[CHUNK_WIDTH-1:0]}
              - {{CHUNK_WIDTH{1'b0}}, borrow_q};
        last  = (idx_q == IDXW'(NCHUNK - 1));
    end

    // State register; reset returns to IDLE and wins over everything.
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                if (last) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: capture on accept, then one slice per RUN cycle. diff is only
    // written in RUN, so it holds steady across DONE until the next operation.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            idx_q    <= '0;
            diff_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= PW'(a);
                        b_q      <= PW'(b);
                        borrow_q <= 1'b0;
                        idx_q    <= '0;
                    end
                end
                RUN: begin
                    // Result bits of the padded region above ADDER_WIDTH are dropped.
                    for (int k = 0; k < ADDER_WIDTH; k++) begin
                        if (k / CHUNK_WIDTH == int'(idx_q))
                            diff_q[k] <= slice[k % CHUNK_WIDTH];
                    end
                    a_q      <= a_q >> CHUNK_WIDTH;
                    b_q      <= b_q >> CHUNK_WIDTH;
                    borrow_q <= slice[CHUNK_WIDTH];
                    idx_q    <= idx_q + IDXW'(1);
                    if (last) diff_q[ADDER_WIDTH] <= slice[CHUNK_WIDTH];
                end
                default: ;
            endcase
        end
    end

    assign diff = diff_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: three instances (CHUNK_WIDTH 32, 116, 7) share
// clock and reset; each has its own handshake signals.
module tb_serial_subtractor;
    localparam int W = 116;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         iv   [3];
    logic         ir   [3];
    logic         ov   [3];
    logic         ordy [3];
    logic [W-1:0] av   [3];
    logic [W-1:0] bv   [3];
    logic [W:0]   dv   [3];
    int           nch  [3] = '{4, 1, 17};

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.ADDER_WIDTH(W), .CHUNK_WIDTH(32)) u0 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(av[0]), .b(bv[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .diff(dv[0]));
    serial_subtractor #(.ADDER_WIDTH(W), .CHUNK_WIDTH(116)) u1 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(av[1]), .b(bv[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .diff(dv[1]));
    serial_subtractor #(.ADDER_WIDTH(W), .CHUNK_WIDTH(7)) u2 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .a(av[2]), .b(bv[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .diff(dv[2]));

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W:0]   exp;
        string        name;
    } vec_t;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd();
        return W'({$urandom, $urandom, $urandom, $urandom});
    endfunction

    // One full transaction on unit u: accept, wait for result with a bounded
    // wait, check latency/value, stall for 'stall' cycles (optionally with new
    // operands offered), then hand the result off.
    task automatic op(input int u, input logic [W-1:0] x, input logic [W-1:0] y,
                      input int stall, input bit noise, input logic [W:0] exp,
                      input string name);
        int         lat;
        bit         steady;
        logic [W:0] held;
        @(negedge clk);
        chk({name, " in_ready"}, 128'(ir[u]), 128'(1));
        iv[u] = 1'b1; av[u] = x; bv[u] = y;
        @(negedge clk);
        iv[u] = 1'b0; av[u] = rnd(); bv[u] = rnd();
        lat = 0;
        while (!ov[u] && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        chk({name, " latency"}, 128'(lat), 128'(nch[u]));
        chk({name, " diff"}, 128'(dv[u]), 128'(exp));
        held   = dv[u];
        steady = 1'b1;
        repeat (stall) begin
            if (noise) begin iv[u] = 1'b1; av[u] = rnd(); bv[u] = rnd(); end
            @(negedge clk);
            if (dv[u] !== held || ov[u] !== 1'b1 || ir[u] !== 1'b0) steady = 1'b0;
        end
        if (stall > 0) chk({name, " hold stable"}, 128'(steady), 128'(1));
        iv[u] = 1'b0; ordy[u] = 1'b1;
        @(negedge clk);
        ordy[u] = 1'b0;
        chk({name, " out_valid drop"}, 128'(ov[u]), 128'(0));
    endtask

    initial begin
        vec_t vecs[7];
        bit   never;
        logic [W-1:0] x, y;

        vecs[0] = '{a: W'(100), b: W'(58), exp: (W+1)'(42), name: "basic"};
        vecs[1] = '{a: W'(0), b: W'(1), exp: {(W+1){1'b1}}, name: "borrow"};
        vecs[2] = '{a: W'(1) << 96, b: W'(1), exp: {21'h0, {96{1'b1}}}, name: "cross_chunk"};
        vecs[3] = '{a: {W{1'b1}}, b: W'(0), exp: {1'b0, {W{1'b1}}}, name: "max_minus_0"};
        vecs[4] = '{a: W'(0), b: {W{1'b1}}, exp: {1'b1, {(W-1){1'b0}}, 1'b1}, name: "0_minus_max"};
        vecs[5] = '{a: {4{29'h1234567}}, b: {4{29'h1234567}}, exp: '0, name: "equal"};
        vecs[6] = '{a: W'(5), b: W'(7), exp: {{W{1'b1}}, 1'b0}, name: "5_minus_7"};

        for (int u = 0; u < 3; u++) begin
            iv[u] = 1'b0; ordy[u] = 1'b0; av[u] = '0; bv[u] = '0;
        end
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            chk("reset out_valid", 128'(ov[u]), 128'(0));
            chk("reset diff", 128'(dv[u]), 128'(0));
            chk("reset in_ready", 128'(ir[u]), 128'(1));
        end
        reset_n = 1'b1;

        // Directed table on every unit.
        for (int u = 0; u < 3; u++)
            for (int i = 0; i < 7; i++)
                op(u, vecs[i].a, vecs[i].b, i % 3, 1'b0, vecs[i].exp, vecs[i].name);

        // Backpressure: 10 stalled cycles with fresh operands offered, then a
        // new pair must go through correctly.
        op(0, W'(1000), W'(1), 10, 1'b1, (W+1)'(999), "backpressure");
        op(0, W'(3), W'(9), 0, 1'b0, {{(W-2){1'b1}}, 3'b010}, "after_bp");

        // Reset on the 2nd RUN cycle aborts the operation.
        @(negedge clk);
        iv[0] = 1'b1; av[0] = W'(77); bv[0] = W'(11);
        @(negedge clk);
        iv[0] = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("abort out_valid", 128'(ov[0]), 128'(0));
        chk("abort diff", 128'(dv[0]), 128'(0));
        chk("abort in_ready", 128'(ir[0]), 128'(1));
        reset_n = 1'b1;
        never = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (ov[0] !== 1'b0) never = 1'b0;
        end
        chk("aborted never presented", 128'(never), 128'(1));
        op(0, W'(5), W'(7), 0, 1'b0, {{W{1'b1}}, 1'b0}, "post_abort");

        // Random regression against the {0,a}-{0,b} model on each unit.
        for (int u = 0; u < 3; u++)
            for (int n = 0; n < 1000; n++) begin
                x = rnd();
                y = rnd();
                case (n % 8)
                    0: y = x;
                    1: x = x >> $urandom_range(0, 115);
                    2: y = W'(1) << $urandom_range(0, 115);
                    default: ;
                endcase
                op(u, x, y, $urandom_range(0, 3), 1'b0, {1'b0, x} - {1'b0, y}, "random");
            end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
